raw2rgb: RTL and testbench

Bayer-to-RGB demosaic stage for the Avalon-ST video pipeline. It consumes the 8-bit Bayer stream produced by the RGB-to-raw stage and rebuilds 24-bit RGB pixels using a causal 2x2 window (current row plus one line buffer). Non-video packets pass through unchanged, zero-extended to 24 bits. It sits directly downstream of the raw stage and feeds any 24-bit RGB consumer.

---
 rtl/raw2rgb.sv | 184 ++++++++++++++++++
 tb/tb_raw2rgb.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/raw2rgb.sv
// Bayer-to-RGB demosaic: rebuilds 24-bit RGB from an 8-bit Bayer Avalon-ST stream
// using a causal 2x2 window (current row plus one line buffer); other packets pass through.
module raw2rgb #(
    parameter int WIDTH  = 1920,
    parameter int HEIGHT = 1080
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  sink_data,
    input  logic        sink_valid,
    input  logic        sink_sop,
    input  logic        sink_eop,
    output logic        sink_ready,
    output logic [23:0] source_data,
    output logic        source_valid,
    output logic        source_sop,
    output logic        source_eop,
    input  logic        source_ready
);

    localparam int AW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [15:0] X_LAST = 16'(WIDTH - 1);

    if (WIDTH < 2 || HEIGHT < 1) begin : g_bad_params
        $error("raw2rgb: WIDTH must be >= 2 and HEIGHT >= 1");
    end

    typedef enum logic [1:0] {IDLE, VIDEO, OTHER} state_t;

    state_t      state, state_nxt;
    logic        fwd, pix, vsop;
    logic [15:0] x_cnt, y_cnt;
    logic [7:0]  line_buf [WIDTH];
    logic [AW-1:0] addr;

    logic        s1_valid, s1_sop, s1_eop, s1_pix;
    logic [7:0]  s1_data, s1_cur, s1_left, s1_up, s1_upleft;
    logic        s1_x0, s1_y0, s1_xo, s1_yo;

    // The upstream stage honours ready, and this pipeline never stalls.
    assign sink_ready = source_ready;
    assign addr = x_cnt[AW-1:0];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        fwd       = 1'b0;
        pix       = 1'b0;
        vsop      = 1'b0;
        if (sink_valid) begin
            if (sink_sop) begin
                fwd = 1'b1;
                if (sink_data[3:0] == 4'h0) begin
                    state_nxt = VIDEO;
                    vsop      = 1'b1;
                end else begin
                    state_nxt = OTHER;
                end
            end else begin
                case (state)
                    VIDEO:   begin fwd = 1'b1; pix = 1'b1; end
                    OTHER:   fwd = 1'b1;
                    default: fwd = 1'b0;
                endcase
            end
            if (sink_eop) state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || vsop) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (pix) begin
            if (x_cnt == X_LAST) begin
                x_cnt <= '0;
                y_cnt <= y_cnt + 16'd1;
            end else begin
                x_cnt <= x_cnt + 16'd1;
            end
        end
    end

    // Line buffer is not reset: rows and columns at the frame edge mask its output.
    always_ff @(posedge clk) begin
        if (pix) line_buf[addr] <= sink_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_sop    <= 1'b0;
            s1_eop    <= 1'b0;
            s1_pix    <= 1'b0;
            s1_data   <= '0;
            s1_cur    <= '0;
            s1_left   <= '0;
            s1_up     <= '0;
            s1_upleft <= '0;
            s1_x0     <= 1'b0;
            s1_y0     <= 1'b0;
            s1_xo     <= 1'b0;
            s1_yo     <= 1'b0;
        end else begin
            s1_valid <= fwd;
            s1_sop   <= fwd && sink_sop;
            s1_eop   <= fwd && sink_eop;
            s1_pix   <= pix;
            s1_data  <= sink_data;
            if (pix) begin
                s1_cur    <= sink_data;
                s1_left   <= s1_cur;
                s1_up     <= line_buf[addr];
                s1_upleft <= s1_up;
                s1_x0     <= (x_cnt == 16'd0);
                s1_y0     <= (y_cnt == 16'd0);
                s1_xo     <= x_cnt[0];
                s1_yo     <= y_cnt[0];
            end
        end
    end

    // Colour code of a Bayer site: 0 = ch0, 1 = G, 2 = ch2.
    function automatic logic [1:0] site_colour(input logic xo, input logic yo);
        if (!xo && !yo)     return 2'd0;
        else if (xo && yo)  return 2'd2;
        else                return 2'd1;
    endfunction

    logic [7:0]  smp [4];
    logic        prs [4];
    logic [1:0]  col [4];
    logic [7:0]  ch0, ch2, g_a, g_b, g_val;
    logic [1:0]  g_n;
    logic [8:0]  g_sum;

    always_comb begin
        smp[0] = s1_cur;    prs[0] = 1'b1;             col[0] = site_colour(s1_xo, s1_yo);
        smp[1] = s1_left;   prs[1] = !s1_x0;           col[1] = site_colour(!s1_xo, s1_yo);
        smp[2] = s1_up;     prs[2] = !s1_y0;           col[2] = site_colour(s1_xo, !s1_yo);
        smp[3] = s1_upleft; prs[3] = !s1_x0 && !s1_y0; col[3] = site_colour(!s1_xo, !s1_yo);
        ch0 = '0;
        ch2 = '0;
        g_a = '0;
        g_b = '0;
        g_n = '0;
        for (int i = 0; i < 4; i++) begin
            if (prs[i]) begin
                case (col[i])
                    2'd0: ch0 = smp[i];
                    2'd2: ch2 = smp[i];
                    default: begin
                        if (g_n == 2'd0) g_a = smp[i];
                        else             g_b = smp[i];
                        g_n = g_n + 2'd1;
                    end
                endcase
            end
        end
        g_sum = {1'b0, g_a} + {1'b0, g_b};
        if (g_n == 2'd2)      g_val = g_sum[8:1];
        else if (g_n == 2'd1) g_val = g_a;
        else                  g_val = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            source_data  <= '0;
            source_valid <= 1'b0;
            source_sop   <= 1'b0;
            source_eop   <= 1'b0;
        end else begin
            source_valid <= s1_valid;
            source_sop   <= s1_sop;
            source_eop   <= s1_eop;
            source_data  <= s1_pix ? {ch2, g_val, ch0} : {16'h0, s1_data};
        end
    end

endmodule

// File: tb/tb_raw2rgb.sv
// Directed bench for raw2rgb (WIDTH=4): expected beats are queued with their due
// cycle when driven, and a negedge monitor pops and compares every output beat.
module tb_raw2rgb;
    localparam int W = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  sink_data;
    logic        sink_valid, sink_sop, sink_eop;
    logic        sink_ready;
    logic [23:0] source_data;
    logic        source_valid, source_sop, source_eop;
    logic        source_ready;

    raw2rgb #(.WIDTH(W), .HEIGHT(4)) dut (
        .clk(clk), .rst(rst),
        .sink_data(sink_data), .sink_valid(sink_valid), .sink_sop(sink_sop),
        .sink_eop(sink_eop), .sink_ready(sink_ready),
        .source_data(source_data), .source_valid(source_valid),
        .source_sop(source_sop), .source_eop(source_eop),
        .source_ready(source_ready)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [25:0] exp_q[$];
    int          exp_t[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Scoreboard: every valid output beat must match the head of the queue on its due cycle.
    always @(negedge clk) begin
        if (!rst && source_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", {8'h0, source_data}, 32'hFFFF_FFFF);
            end else begin
                logic [25:0] e;
                int          t;
                e = exp_q.pop_front();
                t = exp_t.pop_front();
                check("data", {8'h0, source_data}, {8'h0, e[23:0]});
                check("sop", {31'h0, source_sop}, {31'h0, e[25]});
                check("eop", {31'h0, source_eop}, {31'h0, e[24]});
                check("latency", cyc, t);
            end
        end
    end

    // Driver tasks: inputs change 1 time unit after the rising edge.
    task automatic drive(input logic [7:0] d, input logic sop, input logic eop);
        sink_data  = d;
        sink_sop   = sop;
        sink_eop   = eop;
        sink_valid = 1'b1;
        @(posedge clk);
        #1;
        sink_valid = 1'b0;
        sink_sop   = 1'b0;
        sink_eop   = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic sop, input logic eop,
                        input logic [23:0] exp_d);
        exp_q.push_back({sop, eop, exp_d});
        exp_t.push_back(cyc + 2);
        drive(d, sop, eop);
    endtask

    task automatic idle(input int n);
        sink_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Uniform frame of 0x80: ch0 alone at the origin, ch0+G on the first row/column, full mix elsewhere.
    function automatic logic [23:0] flat_exp(input int x, input int y);
        if (x == 0 && y == 0)      return 24'h000080;
        else if (x == 0 || y == 0) return 24'h008080;
        else                       return 24'h808080;
    endfunction

    task automatic flat_pixels(input int n, input logic eop_last);
        for (int i = 0; i < n; i++)
            send(8'h80, 1'b0, eop_last && (i == n - 1), flat_exp(i % W, i / W));
    endtask

    initial begin
        logic [7:0] r;
        logic [7:0] v [5];

        rst = 1'b1; source_ready = 1'b1;
        sink_data = 8'h00; sink_valid = 1'b1; sink_sop = 1'b1; sink_eop = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", {8'h0, source_data}, 32'h0);
        check("rst_valid", {31'h0, source_valid}, 32'h0);
        check("rst_sop", {31'h0, source_sop}, 32'h0);
        check("rst_eop", {31'h0, source_eop}, 32'h0);
        rst = 1'b0;
        sink_valid = 1'b0; sink_sop = 1'b0;
        for (int i = 0; i < 3; i++) drive(8'($urandom_range(0, 255)), 1'b0, 1'b0);
        idle(4);

        source_ready = 1'b0; #1;
        check("ready_low", {31'h0, sink_ready}, 32'h0);
        source_ready = 1'b1; #1;
        check("ready_high", {31'h0, sink_ready}, 32'h1);

        send(8'h0F, 1'b1, 1'b0, 24'h00000F);
        send(8'hAA, 1'b0, 1'b0, 24'h0000AA);
        send(8'h55, 1'b0, 1'b1, 24'h000055);
        drive(8'h77, 1'b0, 1'b0);
        idle(3);

        send(8'h03, 1'b1, 1'b0, 24'h000003);
        for (int i = 0; i < 3; i++) begin
            r = 8'($urandom_range(0, 255));
            send(r, 1'b0, i == 2, {16'h0, r});
        end
        idle(2);

        send(8'h00, 1'b1, 1'b0, 24'h000000);
        flat_pixels(16, 1'b1);
        idle(3);

        send(8'h00, 1'b1, 1'b0, 24'h000000);
        send(8'h10, 1'b0, 1'b0, 24'h000010);
        send(8'h20, 1'b0, 1'b0, 24'h002010);
        send(8'h30, 1'b0, 1'b0, 24'h002030);
        send(8'h44, 1'b0, 1'b0, 24'h004430);
        send(8'h31, 1'b0, 1'b0, 24'h003110);
        send(8'h40, 1'b0, 1'b1, 24'h402810);
        idle(3);

        for (int i = 0; i < 5; i++) v[i] = 8'($urandom_range(1, 255));
        send(8'h00, 1'b1, 1'b0, 24'h000000);
        send(v[0], 1'b0, 1'b0, {16'h0, v[0]});
        send(v[1], 1'b0, 1'b0, {8'h0, v[1], v[0]});
        send(v[2], 1'b0, 1'b0, {8'h0, v[1], v[2]});
        send(v[3], 1'b0, 1'b0, {8'h0, v[3], v[2]});
        send(v[4], 1'b0, 1'b1, {8'h0, v[4], v[0]});
        send(8'h00, 1'b1, 1'b0, 24'h000000);
        flat_pixels(16, 1'b1);
        idle(3);

        send(8'h00, 1'b1, 1'b0, 24'h000000);
        flat_pixels(6, 1'b0);
        send(8'h00, 1'b1, 1'b0, 24'h000000);
        flat_pixels(16, 1'b1);
        idle(3);

        // Reset with beats in flight: nothing may emerge afterwards.
        drive(8'h00, 1'b1, 1'b0);
        rst = 1'b1;
        drive(8'h80, 1'b0, 1'b0);
        rst = 1'b0;
        idle(4);

        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
